// File: rtl/nrzi_4b5b_pkg.sv
// Shared 4B5B symbol constants, code table, lane FSM states and symbol decode.
package nrzi_4b5b_pkg;

   localparam logic [4:0] SYM_I = 5'b11111;
   localparam logic [4:0] SYM_J = 5'b11000;
   localparam logic [4:0] SYM_K = 5'b10001;
   localparam logic [4:0] SYM_T = 5'b01101;
   localparam logic [4:0] SYM_R = 5'b00111;
   localparam logic [4:0] SYM_H = 5'b00100;

   // Index is the data nibble value.
   localparam logic [0:15][4:0] DATA_CODES = {
      5'b11110, 5'b01001, 5'b10100, 5'b10101,
      5'b01010, 5'b01011, 5'b01110, 5'b01111,
      5'b10010, 5'b10011, 5'b10110, 5'b10111,
      5'b11010, 5'b11011, 5'b11100, 5'b11101
   };

   typedef enum logic [1:0] {DATA, CTRL, INVALID} sym_kind_e;

   typedef enum logic [2:0] {HUNT, JSEEN, SOF, FRAME, TSEEN} lane_state_e;

   typedef struct packed {
      sym_kind_e  kind;
      logic [3:0] nibble;
   } sym_dec_t;

   function automatic sym_dec_t decode_sym(input logic [4:0] sym);
      sym_dec_t r;
      r.kind   = INVALID;
      r.nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (sym == DATA_CODES[i]) begin
            r.kind   = DATA;
            r.nibble = 4'(i);
         end
      end
      if (sym inside {SYM_I, SYM_J, SYM_K, SYM_T, SYM_R, SYM_H})
         r.kind = CTRL;
      return r;
   endfunction

endpackage

// File: rtl/nrzi_4b5b_lane.sv
// One receive lane: NRZI history, two-stage pipeline, framing FSM, error counter.
// Error counter is present only when NRZI_4B5B_ERRCNT_EN is defined.
//
// state | meaning
// HUNT  | idle, waiting for J
// JSEEN | J seen, expecting K
// SOF   | J/K delimiter done, expecting first data or T
// FRAME | inside frame, data or T expected
// TSEEN | T seen, expecting R
module nrzi_4b5b_lane
   import nrzi_4b5b_pkg::*;
#(
   parameter int ERRCNT_W = 8
) (
   input  logic                clk80,
   input  logic                reset,
   input  logic                en_i,
   input  logic [4:0]          din_i,
   input  logic                err_clr_i,
   output logic [3:0]          dout_o,
   output logic                dvalid_o,
   output logic                sop_o,
   output logic                eop_o,
   output logic                error_o,
   output logic [ERRCNT_W-1:0] err_count_o
);

   logic        hist_q;
   logic [4:0]  sym_d, sym_q;
   logic        stb_q;
   lane_state_e state_q, state_d;
   logic [3:0]  dout_q, dout_d;
   logic        dvalid_q, dvalid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
   sym_dec_t    dec;

   // A line transition decodes to 1; bit 4 is compared against the previous symbol's bit 0.
   always_comb begin
      sym_d = {din_i[4] ^ hist_q, din_i[3:0] ^ din_i[4:1]};
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         hist_q <= 1'b0;
         sym_q  <= 5'd0;
         stb_q  <= 1'b0;
      end else begin
         stb_q <= en_i;
         if (en_i) begin
            sym_q  <= sym_d;
            hist_q <= din_i[0];
         end
      end
   end

   always_comb begin
      dec      = decode_sym(sym_q);
      state_d  = state_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      err_d    = 1'b0;
      if (stb_q) begin
         case (state_q)
            HUNT: begin
               if (sym_q == SYM_J)          state_d = JSEEN;
               else if (dec.kind == INVALID) err_d  = 1'b1;
            end
            JSEEN: begin
               if (sym_q == SYM_K) state_d = SOF;
               else begin
                  state_d = HUNT;
                  err_d   = 1'b1;
               end
            end
            SOF, FRAME: begin
               if (dec.kind == DATA) begin
                  state_d  = FRAME;
                  dvalid_d = 1'b1;
                  sop_d    = (state_q == SOF);
                  dout_d   = dec.nibble;
               end else if (sym_q == SYM_T) begin
                  state_d = TSEEN;
               end else begin
                  state_d = HUNT;
                  err_d   = 1'b1;
               end
            end
            TSEEN: begin
               state_d = HUNT;
               if (sym_q == SYM_R) eop_d = 1'b1;
               else                err_d = 1'b1;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         state_q  <= HUNT;
         dout_q   <= 4'h0;
         dvalid_q <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         err_q    <= err_d;
      end
   end

   assign dout_o   = dout_q;
   assign dvalid_o = dvalid_q;
   assign sop_o    = sop_q;
   assign eop_o    = eop_q;
   assign error_o  = err_q;

`ifdef NRZI_4B5B_ERRCNT_EN
   logic [ERRCNT_W-1:0] cnt_q;

   // Counts visible error pulses; a clear in the same cycle wins over the increment.
   always_ff @(posedge clk80 or posedge reset) begin
      if (reset)                     cnt_q <= '0;
      else if (err_clr_i)            cnt_q <= '0;
      else if (err_q && cnt_q != '1) cnt_q <= cnt_q + ERRCNT_W'(1);
   end

   assign err_count_o = cnt_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr_i;
   assign err_count_o    = '0;
`endif

endmodule

// File: rtl/nrzi_4b5b_decoder_mc.sv
// Multi-lane NRZI/4B5B receive decoder: one independent lane per channel.
// Per-lane error counters are built only when NRZI_4B5B_ERRCNT_EN is defined.
module nrzi_4b5b_decoder_mc #(
   parameter int CHANNELS = 4,
   parameter int ERRCNT_W = 8
) (
   input  logic                         clk80,
   input  logic                         reset,
   input  logic [CHANNELS-1:0]          en,
   input  logic [5*CHANNELS-1:0]        din,
   output logic [4*CHANNELS-1:0]        dout,
   output logic [CHANNELS-1:0]          dvalid,
   output logic [CHANNELS-1:0]          sop,
   output logic [CHANNELS-1:0]          eop,
   output logic [CHANNELS-1:0]          error,
   input  logic                         err_clr,
   output logic [ERRCNT_W*CHANNELS-1:0] err_count
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      nrzi_4b5b_lane #(.ERRCNT_W(ERRCNT_W)) u_lane (
         .clk80       (clk80),
         .reset       (reset),
         .en_i        (en[i]),
         .din_i       (din[5*i +: 5]),
         .err_clr_i   (err_clr),
         .dout_o      (dout[4*i +: 4]),
         .dvalid_o    (dvalid[i]),
         .sop_o       (sop[i]),
         .eop_o       (eop[i]),
         .error_o     (error[i]),
         .err_count_o (err_count[ERRCNT_W*i +: ERRCNT_W])
      );
   end

endmodule
